// File: rtl/mod_accum_fsm.sv
// mod_accum_fsm: running sum of qualified words mod MOD with target match, wrap/tgt_err pulses and saturating match counter
module mod_accum_fsm #(
  parameter int IN_W = 2,
  parameter int MOD = 4,
  parameter int TARGET = 1,
  parameter int CNT_W = 8,
  localparam int RES_W = ($clog2(MOD) > 1) ? $clog2(MOD) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  input  logic             clear,
  input  logic             target_ld,
  input  logic [RES_W-1:0] target_in,
  output logic [RES_W-1:0] residue,
  output logic             match,
  output logic             wrap,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat,
  output logic             tgt_err
);
  localparam int SUM_W = ((RES_W > IN_W) ? RES_W : IN_W) + 1;
  logic [SUM_W-1:0] sum;
  logic [RES_W-1:0] res_nx, tgt;
  logic tgt_ok;
  always_comb begin
    sum = SUM_W'(residue) + SUM_W'(in_data);
    res_nx = RES_W'(sum % SUM_W'(MOD));
    tgt_ok = {1'b0, target_in} < (RES_W+1)'(MOD);
  end
  assign match = residue == tgt;
  assign cnt_sat = &match_cnt;
  always_ff @(posedge CLK) begin
    if (RST) begin
      residue <= '0;
      tgt <= RES_W'(TARGET);
      match_cnt <= '0;
      wrap <= 1'b0;
      tgt_err <= 1'b0;
    end else if (clear) begin
      residue <= '0;
      match_cnt <= '0;
      wrap <= 1'b0;
      tgt_err <= 1'b0;
    end else begin
      residue <= in_valid ? res_nx : residue;
      wrap <= in_valid && (sum >= SUM_W'(MOD));
      match_cnt <= (in_valid && res_nx == tgt && !cnt_sat) ? match_cnt + CNT_W'(1) : match_cnt;
      tgt <= (target_ld && tgt_ok) ? target_in : tgt;
      tgt_err <= target_ld && !tgt_ok;
    end
  end
endmodule

// File: tb/tb_mod_accum_fsm.sv
// tb_mod_accum_fsm: directed checks of three mod_accum_fsm configurations
module tb_mod_accum_fsm;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int checks = 0;
  int failures = 0;
  always #5 CLK = ~CLK;
  logic a_v = 0, a_c = 0, a_tl = 0;
  logic [1:0] a_d = 0, a_ti = 0, a_res;
  logic a_m, a_w, a_s, a_e;
  logic [7:0] a_cnt;
  mod_accum_fsm dut_a (
    .CLK(CLK), .RST(RST), .in_valid(a_v), .in_data(a_d), .clear(a_c),
    .target_ld(a_tl), .target_in(a_ti), .residue(a_res), .match(a_m),
    .wrap(a_w), .match_cnt(a_cnt), .cnt_sat(a_s), .tgt_err(a_e)
  );
  logic b_v = 0, b_c = 0, b_tl = 0;
  logic [2:0] b_d = 0, b_ti = 0, b_res;
  logic b_m, b_w, b_s, b_e;
  logic [7:0] b_cnt;
  mod_accum_fsm #(.IN_W(3), .MOD(5), .TARGET(2)) dut_b (
    .CLK(CLK), .RST(RST), .in_valid(b_v), .in_data(b_d), .clear(b_c),
    .target_ld(b_tl), .target_in(b_ti), .residue(b_res), .match(b_m),
    .wrap(b_w), .match_cnt(b_cnt), .cnt_sat(b_s), .tgt_err(b_e)
  );
  logic c_v = 0, c_c = 0, c_tl = 0;
  logic [2:0] c_d = 0;
  logic [1:0] c_ti = 0, c_res, c_cnt;
  logic c_m, c_w, c_s, c_e;
  mod_accum_fsm #(.IN_W(3), .MOD(4), .TARGET(0), .CNT_W(2)) dut_c (
    .CLK(CLK), .RST(RST), .in_valid(c_v), .in_data(c_d), .clear(c_c),
    .target_ld(c_tl), .target_in(c_ti), .residue(c_res), .match(c_m),
    .wrap(c_w), .match_cnt(c_cnt), .cnt_sat(c_s), .tgt_err(c_e)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic step_a(input logic v, input logic [1:0] d, input logic c, input logic tl, input logic [1:0] ti);
    a_v = v; a_d = d; a_c = c; a_tl = tl; a_ti = ti;
    tick();
    a_v = 0; a_c = 0; a_tl = 0;
  endtask
  task automatic step_b(input logic v, input logic [2:0] d, input logic tl, input logic [2:0] ti);
    b_v = v; b_d = d; b_tl = tl; b_ti = ti;
    tick();
    b_v = 0; b_tl = 0;
  endtask
  initial begin
    #100000;
    failures++;
    $error("FAIL timeout: stimulus did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    logic [1:0] a_in [6] = '{2'd3, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3};
    logic [1:0] a_rx [6] = '{2'd3, 2'd0, 2'd1, 2'd3, 2'd2, 2'd1};
    logic a_mx [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic a_wx [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0] c_cx [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic c_sx [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tick();
    tick();
    RST = 0;
    chk("rst_res", a_res, 2'd0);
    chk("rst_match", a_m, 1'b0);
    chk("rst_cnt", a_cnt, 8'd0);
    chk("rst_wrap", a_w, 1'b0);
    chk("rst_err", a_e, 1'b0);
    chk("rst_c_match", c_m, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step_a(1, a_in[i], 0, 0, 0);
      chk("seq_res", a_res, a_rx[i]);
      chk("seq_match", a_m, a_mx[i]);
      chk("seq_wrap", a_w, a_wx[i]);
    end
    chk("seq_cnt", a_cnt, 8'd2);
    step_a(0, 0, 1, 0, 0);
    chk("clr_res", a_res, 2'd0);
    chk("clr_cnt", a_cnt, 8'd0);
    step_a(1, 1, 0, 0, 0);
    chk("tog_res0", a_res, 2'd1);
    chk("tog_wrap0", a_w, 1'b0);
    step_a(0, 3, 0, 0, 0);
    chk("tog_res1", a_res, 2'd1);
    chk("tog_wrap1", a_w, 1'b0);
    chk("tog_cnt1", a_cnt, 8'd1);
    step_a(1, 1, 0, 0, 0);
    chk("tog_res2", a_res, 2'd2);
    chk("tog_wrap2", a_w, 1'b0);
    chk("tog_cnt2", a_cnt, 8'd1);
    step_a(0, 0, 1, 0, 0);
    step_a(1, 3, 0, 1, 3);
    chk("ld_res", a_res, 2'd3);
    chk("ld_cnt_old_tgt", a_cnt, 8'd0);
    chk("ld_match_new", a_m, 1'b1);
    chk("ld_err", a_e, 1'b0);
    step_a(1, 2, 0, 0, 0);
    chk("pre_clr_wrap", a_w, 1'b1);
    step_a(1, 1, 1, 1, 0);
    chk("clrv_res", a_res, 2'd0);
    chk("clrv_cnt", a_cnt, 8'd0);
    chk("clrv_wrap", a_w, 1'b0);
    chk("clrv_match", a_m, 1'b0);
    step_a(1, 3, 0, 0, 0);
    chk("clrv_tgt_kept", a_m, 1'b1);
    chk("clrv_cnt1", a_cnt, 8'd1);
    RST = 1;
    step_a(1, 3, 0, 0, 0);
    RST = 0;
    chk("mrst_res", a_res, 2'd0);
    chk("mrst_cnt", a_cnt, 8'd0);
    chk("mrst_wrap", a_w, 1'b0);
    chk("mrst_match", a_m, 1'b0);
    step_a(1, 1, 0, 0, 0);
    chk("mrst_tgt", a_m, 1'b1);
    chk("mrst_cnt1", a_cnt, 8'd1);
    step_b(1, 7, 0, 0);
    chk("m5_res0", b_res, 3'd2);
    chk("m5_wrap0", b_w, 1'b1);
    chk("m5_match0", b_m, 1'b1);
    step_b(1, 5, 0, 0);
    chk("m5_res1", b_res, 3'd2);
    chk("m5_wrap1", b_w, 1'b1);
    chk("m5_cnt", b_cnt, 8'd2);
    step_b(0, 0, 1, 7);
    chk("err7", b_e, 1'b1);
    chk("err7_match", b_m, 1'b1);
    step_b(0, 0, 0, 0);
    chk("err_pulse_end", b_e, 1'b0);
    chk("err_tgt_kept", b_m, 1'b1);
    step_b(0, 0, 1, 5);
    chk("err5", b_e, 1'b1);
    step_b(0, 0, 1, 7);
    chk("err_b2b", b_e, 1'b1);
    step_b(0, 0, 1, 4);
    chk("ld4_err", b_e, 1'b0);
    chk("ld4_match", b_m, 1'b0);
    for (int i = 0; i < 5; i++) begin
      c_v = 1; c_d = 3'd4;
      tick();
      c_v = 0;
      chk("sat_res", c_res, 2'd0);
      chk("sat_wrap", c_w, 1'b1);
      chk("sat_cnt", c_cnt, c_cx[i]);
      chk("sat_flag", c_s, c_sx[i]);
    end
    c_c = 1;
    tick();
    c_c = 0;
    chk("sat_clr_cnt", c_cnt, 2'd0);
    chk("sat_clr_flag", c_s, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
